// File: rtl/elastic_pipeline.sv
// Elastic valid/ready pipeline of DEPTH stages. Each stage advances on its own,
// so bubbles collapse and backpressure ripples back combinationally to in_ready.
module elastic_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] adv_s;
  logic [DEPTH-1:0] src_v_s;
  logic [WIDTH-1:0] src_d_s [DEPTH];
  logic [CW-1:0]    count_q;
  logic             busy_q;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [CW-1:0] acc;
    acc = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CW'(vec[i]);
    end
    return acc;
  endfunction

  // A stage may advance unless it and every stage downstream of it are full while the sink stalls.
  always_comb begin : adv_chain
    logic tail_full;
    tail_full = 1'b1;
    adv_s     = {DEPTH{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v_q[i];
      adv_s[i]  = ~tail_full | out_ready;
    end
  end

  // Source feeding each stage: upstream port for stage 0, previous stage otherwise.
  always_comb begin
    src_v_s    = {DEPTH{1'b0}};
    src_v_s[0] = in_valid;
    src_d_s[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v_s[i] = v_q[i-1];
      src_d_s[i] = d_q[i-1];
    end
  end

  // Next-state: flush drops all valid bits but leaves data untouched.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv_s[i]) begin
          v_d[i] = src_v_s[i];
          d_d[i] = src_d_s[i];
        end else begin
          v_d[i] = v_q[i];
          d_d[i] = d_q[i];
        end
      end
    end
  end

  // Stage registers plus occupancy/busy kept registered alongside the valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= {DEPTH{1'b0}};
      count_q <= {CW{1'b0}};
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= popcount(v_d);
      busy_q  <= |v_d;
    end
  end

  assign in_ready  = adv_s[0] & ~flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Scoreboard bench: a DEPTH=4/WIDTH=8 and a DEPTH=1/WIDTH=32 pipeline, each checked
// against a FIFO-of-accepted-beats model that also predicts count and in_ready.
module tb_elastic_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_data, b_out_data;
  logic [0:0]  b_count;

  int errors = 0;
  int checks = 0;
  logic [7:0]  qa [$];
  logic [31:0] qb [$];

  elastic_pipeline #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy), .count(a_count)
  );

  elastic_pipeline #(.WIDTH(32), .DEPTH(1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy), .count(b_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: the model's occupancy is the number of accepted, undelivered beats.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      chk("a_count", 32'(a_count), 32'(qa.size()));
      chk("a_busy", 32'(a_busy), 32'(qa.size() != 0));
      chk("a_in_ready", 32'(a_in_ready), 32'(!a_flush && (qa.size() < 4 || a_out_ready)));
      if (a_out_valid) begin
        if (qa.size() == 0) chk("a_spurious_valid", 32'(a_out_valid), 32'd0);
        else begin
          chk("a_out_data", 32'(a_out_data), 32'(qa[0]));
          if (a_out_ready) void'(qa.pop_front());
        end
      end
      if (a_flush) qa.delete();
      if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
    end else begin
      chk("b_count", 32'(b_count), 32'(qb.size()));
      chk("b_busy", 32'(b_busy), 32'(qb.size() != 0));
      chk("b_in_ready", 32'(b_in_ready), 32'(!b_flush && (qb.size() < 1 || b_out_ready)));
      if (b_out_valid) begin
        if (qb.size() == 0) chk("b_spurious_valid", 32'(b_out_valid), 32'd0);
        else begin
          chk("b_out_data", b_out_data, qb[0]);
          if (b_out_ready) void'(qb.pop_front());
        end
      end
      if (b_flush) qb.delete();
      if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
    end
  end

  initial begin
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 32'h0; b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);

    // Streaming at full rate: beat k+1 presented in cycle k, visible in cycle k+4.
    a_out_ready = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      a_in_valid = (c < 16);
      a_in_data  = 8'(c + 1);
      #1;
      if (c == 3) chk("stream_latency_pre", 32'(a_out_valid), 32'd0);
      if (c >= 4) begin
        chk("stream_valid", 32'(a_out_valid), 32'd1);
        chk("stream_data", 32'(a_out_data), 32'(c - 3));
      end
      if (c >= 4 && c < 16) chk("stream_count", 32'(a_count), 32'd4);
      tick();
    end
    a_in_valid = 1'b0;
    repeat (2) tick();
    chk("stream_drained", 32'(a_count), 32'd0);

    // Backpressure on a full pipe, then one release cycle with simultaneous in/out.
    a_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'hA0 + 8'(k);
      tick();
    end
    a_in_data = 8'hA4;
    for (int r = 0; r < 3; r++) begin
      #1;
      chk("bp_count", 32'(a_count), 32'd4);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      chk("bp_hold_data", 32'(a_out_data), 32'hA0);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_in_ready), 32'd1);
    tick();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    #1;
    chk("bp_after_count", 32'(a_count), 32'd4);
    chk("bp_after_data", 32'(a_out_data), 32'hA1);
    a_out_ready = 1'b1;
    repeat (6) tick();

    // Bubble collapse under a stalled sink.
    a_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = (k % 2 == 0);
      a_in_data  = (k == 0) ? 8'h11 : 8'h22;
      tick();
    end
    a_in_valid = 1'b0;
    #1;
    chk("bubble_count", 32'(a_count), 32'd2);
    chk("bubble_in_ready", 32'(a_in_ready), 32'd1);
    repeat (4) tick();
    chk("bubble_v", 32'(dut_a.v_q), 32'b1100);
    chk("bubble_head", 32'(a_out_data), 32'h11);
    a_out_ready = 1'b1;
    repeat (4) tick();

    // Flush with an input beat offered in the same cycle.
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'h31 + 8'(k);
      tick();
    end
    a_in_valid = 1'b0;
    repeat (3) tick();
    chk("flush_pre_count", 32'(a_count), 32'd3);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h55;
    #1;
    chk("flush_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_out_valid", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("flush_no_55", 32'(a_out_valid), 32'd0);
      tick();
    end

    // Asynchronous reset with three beats in flight.
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'h41 + 8'(k);
      tick();
    end
    a_in_valid = 1'b0;
    tick();
    chk("mid_rst_pre_count", 32'(a_count), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_count", 32'(a_count), 32'd0);
    chk("mid_rst_out_data", 32'(a_out_data), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(a_in_ready), 32'd1);
    tick();

    // Random traffic on the 4-stage instance, including occasional flushes.
    for (int k = 0; k < 3000; k++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_data   = 8'($urandom);
      a_out_ready = ($urandom_range(0, 2) != 0) ^ (k[9] == 1'b1 && $urandom_range(0, 1) == 0);
      a_flush     = ($urandom_range(0, 40) == 0);
      tick();
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    repeat (6) tick();
    chk("a_final_empty", 32'(a_count), 32'd0);

    // Random traffic on the single-register 32-bit instance.
    for (int k = 0; k < 10000; k++) begin
      b_in_valid  = ($urandom_range(0, 2) != 0);
      b_in_data   = $urandom;
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 60) == 0);
      tick();
    end
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (3) tick();
    chk("b_final_empty", 32'(b_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
